// File: rtl/arm_block_xfer_seq_if.sv
// ---------------------------------------------------------------------------
// arm_block_xfer_seq_if
// Bundles the block-transfer sequencer's launch, register-file and memory
// signals.
//   start/inst/rn_value       : launch request and captured operands
//   reg_rd_addr/reg_rd_data   : combinational register-file read port
//   reg_wr_en/addr/data       : register-file write port
//   mem_req/we/addr/wdata     : memory request (held until mem_ready)
//   mem_ready/mem_rdata       : memory completion and load data
//   busy/done                 : stall indication and completion pulse
// Modport master is the sequencer; modport slave is the core/memory side.
// ---------------------------------------------------------------------------
interface arm_block_xfer_seq_if;
    logic        start;
    logic [31:0] inst;
    logic [31:0] rn_value;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    modport master (
        input  start, inst, rn_value, reg_rd_data, mem_ready, mem_rdata,
        output reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        output start, inst, rn_value, reg_rd_data, mem_ready, mem_rdata,
        input  reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/arm_block_xfer_seq.sv
// ---------------------------------------------------------------------------
// arm_block_xfer_seq
// Multi-cycle sequencer for ARM LDM/STM. Walks the 16-bit register list in
// ascending order, issuing one word transfer per listed register over a
// request/ready handshake, then optionally writes back the base register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arm_block_xfer_seq_if.master (launch, register file, memory,
//           busy/done)
// ---------------------------------------------------------------------------
module arm_block_xfer_seq (
    input logic                  clk,
    input logic                  rst_n,
    arm_block_xfer_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rn_q, rn_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_q, wb_d;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Scan downward so the lowest set bit is the one left standing.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic        p_bit, u_bit, w_bit, l_bit;
    logic [3:0]  rn_idx;
    logic [15:0] list;
    logic [4:0]  n_regs;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [3:0]  cur;
    logic [15:0] cur_oh;
    logic [15:0] mask_rest;

    assign p_bit     = inst_q[24];
    assign u_bit     = inst_q[23];
    assign w_bit     = inst_q[21];
    assign l_bit     = inst_q[20];
    assign rn_idx    = inst_q[19:16];
    assign list      = inst_q[15:0];
    assign n_regs    = popcount16(list);
    assign four_n    = {25'd0, n_regs, 2'b00};
    assign cur       = lowest_idx(mask_q);
    assign cur_oh    = 16'h0001 << cur;
    assign mask_rest = mask_q & ~cur_oh;

    always_comb begin
        case ({p_bit, u_bit})
            2'b01:   start_addr = rn_q;                      // IA
            2'b11:   start_addr = rn_q + 32'd4;              // IB
            2'b00:   start_addr = rn_q - four_n + 32'd4;     // DA
            default: start_addr = rn_q - four_n;             // DB
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and walk registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= 32'd0;
            rn_q   <= 32'd0;
            mask_q <= 16'd0;
            addr_q <= 32'd0;
            wb_q   <= 32'd0;
        end else begin
            inst_q <= inst_d;
            rn_q   <= rn_d;
            mask_q <= mask_d;
            addr_q <= addr_d;
            wb_q   <= wb_d;
        end
    end

    always_comb begin
        inst_d = inst_q;
        rn_d   = rn_q;
        mask_d = mask_q;
        addr_d = addr_q;
        wb_d   = wb_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    inst_d = bus.inst;
                    rn_d   = bus.rn_value;
                end
            end
            S_SETUP: begin
                mask_d = list;
                addr_d = start_addr;
                wb_d   = u_bit ? (rn_q + four_n) : (rn_q - four_n);
            end
            S_XFER: begin
                if (bus.mem_ready) begin
                    mask_d = mask_rest;
                    addr_d = addr_q + 32'd4;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SETUP;
            S_SETUP: state_d = (n_regs == 5'd0) ? S_DONE : S_XFER;
            S_XFER: begin
                if (bus.mem_ready && (mask_rest == 16'd0)) begin
                    state_d = w_bit ? S_WB : S_DONE;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: every output is decoded from state, so an asynchronous
    // reset zeroes them all immediately.
    always_comb begin
        bus.reg_rd_addr = 4'd0;
        bus.reg_wr_en   = 1'b0;
        bus.reg_wr_addr = 4'd0;
        bus.reg_wr_data = 32'd0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = 32'd0;
        bus.mem_wdata   = 32'd0;
        bus.busy        = (state_q != S_IDLE);
        bus.done        = 1'b0;
        case (state_q)
            S_XFER: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = ~l_bit;
                bus.mem_addr = addr_q;
                if (!l_bit) begin
                    bus.reg_rd_addr = cur;
                    bus.mem_wdata   = bus.reg_rd_data;
                end else if (bus.mem_ready) begin
                    bus.reg_wr_en   = 1'b1;
                    bus.reg_wr_addr = cur;
                    bus.reg_wr_data = bus.mem_rdata;
                end
            end
            S_WB: begin
                // A load that included the base keeps the loaded value.
                if (!(l_bit && list[rn_idx])) begin
                    bus.reg_wr_en   = 1'b1;
                    bus.reg_wr_addr = rn_idx;
                    bus.reg_wr_data = wb_q;
                end
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_block_xfer_seq.sv
module tb_arm_block_xfer_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    arm_block_xfer_seq_if bus();

    arm_block_xfer_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed register-file contents seen through the read port.
    function automatic logic [31:0] rf_val(input logic [3:0] idx);
        case (idx)
            4'd2:    return 32'h0000_00AA;
            4'd3:    return 32'h0000_00BB;
            default: return 32'hA000_0000 | {28'd0, idx};
        endcase
    endfunction

    assign bus.reg_rd_data = rf_val(bus.reg_rd_addr);

    function automatic logic [31:0] mk(input logic p, input logic u, input logic w,
                                       input logic l, input logic [3:0] rn,
                                       input logic [15:0] lst);
        return {7'd0, p, u, 1'b0, w, l, rn, lst};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] rn;
        int          waits;
        bit          pulse;
        int          lat;
        int          nacc;
        logic [31:0] a0, d0, a1, d1;
        int          nwr;
        logic [3:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  wa2;
        logic [31:0] wd2;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int          cyc, hold, nacc, nwr;
        bit          got_done, stable, ld;
        logic [31:0] acc_a[8], acc_d[8];
        logic        acc_we[8];
        logic [3:0]  wr_a[8];
        logic [31:0] wr_d[8];
        logic [31:0] cap_a, cap_d;
        logic        cap_we;
        ld = v.inst[20];
        cyc = 0; hold = 0; nacc = 0; nwr = 0; got_done = 0; stable = 1;
        cap_a = 0; cap_d = 0; cap_we = 0;
        @(negedge clk);
        bus.inst = v.inst; bus.rn_value = v.rn; bus.start = 1'b1;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'd0;
            bus.start     = 1'b0;
            if (cyc == 1) chk({v.name, "/busy_rise"}, bus.busy, 1);
            if (v.pulse && cyc == 2) begin
                bus.start = 1'b1;
                bus.inst  = mk(0, 1, 1, 0, 4'd1, 16'hFFFF);
            end
            if (bus.done) begin
                got_done = 1;
                if (v.pulse) begin
                    bus.start = 1'b1;
                    bus.inst  = mk(0, 1, 1, 0, 4'd1, 16'hFFFF);
                end
            end else if (bus.mem_req) begin
                if (hold == 0) begin
                    cap_a = bus.mem_addr; cap_we = bus.mem_we; cap_d = bus.mem_wdata;
                    stable = 1;
                end else if (bus.mem_addr !== cap_a || bus.mem_we !== cap_we ||
                             bus.mem_wdata !== cap_d) begin
                    stable = 0;
                end
                if (hold == v.waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = ld ? ((nacc == 0) ? v.d0 : v.d1) : 32'd0;
                    if (nacc < 8) begin
                        acc_a[nacc] = cap_a; acc_we[nacc] = cap_we; acc_d[nacc] = cap_d;
                    end
                    if (v.waits > 0) chk({v.name, "/req_stable"}, stable, 1);
                    nacc++;
                    hold = 0;
                end else begin
                    hold++;
                end
            end
            #1;
            if (bus.reg_wr_en) begin
                if (nwr < 8) begin
                    wr_a[nwr] = bus.reg_wr_addr; wr_d[nwr] = bus.reg_wr_data;
                end
                nwr++;
            end
        end
        chk({v.name, "/latency"}, got_done ? cyc : 999, v.lat);
        chk({v.name, "/n_access"}, nacc, v.nacc);
        if (v.nacc > 0 && nacc > 0) begin
            chk({v.name, "/addr0"}, acc_a[0], v.a0);
            chk({v.name, "/we0"}, acc_we[0], !ld);
            if (!ld) chk({v.name, "/wdata0"}, acc_d[0], v.d0);
        end
        if (v.nacc > 1 && nacc > 1) begin
            chk({v.name, "/addr1"}, acc_a[1], v.a1);
            chk({v.name, "/we1"}, acc_we[1], !ld);
            if (!ld) chk({v.name, "/wdata1"}, acc_d[1], v.d1);
        end
        chk({v.name, "/n_regwr"}, nwr, v.nwr);
        if (v.nwr > 0 && nwr > 0) chk({v.name, "/wr0"}, {wr_a[0], wr_d[0]}, {v.wa0, v.wd0});
        if (v.nwr > 1 && nwr > 1) chk({v.name, "/wr1"}, {wr_a[1], wr_d[1]}, {v.wa1, v.wd1});
        if (v.nwr > 2 && nwr > 2) chk({v.name, "/wr2"}, {wr_a[2], wr_d[2]}, {v.wa2, v.wd2});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            chk({v.name, "/idle_after"}, {bus.busy, bus.mem_req, bus.reg_wr_en}, 3'b000);
        end
    endtask

    initial begin
        int seen;
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.inst = 32'd0; bus.rn_value = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;

        vecs[0] = '{"stmia", mk(0,1,1,0,4'd1,16'h000C), 32'h1000, 0, 1, 5, 2,
                    32'h1000, 32'hAA, 32'h1004, 32'hBB,
                    1, 4'd1, 32'h1008, 4'd0, 32'd0, 4'd0, 32'd0};
        vecs[1] = '{"ldmdb", mk(1,0,0,1,4'd6,16'h8001), 32'h2000, 0, 0, 4, 2,
                    32'h1FF8, 32'h1234_5678, 32'h1FFC, 32'h9ABC_DEF0,
                    2, 4'd0, 32'h1234_5678, 4'd15, 32'h9ABC_DEF0, 4'd0, 32'd0};
        vecs[2] = '{"ldmia_rn_in_list", mk(0,1,1,1,4'd4,16'h0030), 32'h3000, 0, 0, 5, 2,
                    32'h3000, 32'h11, 32'h3004, 32'h22,
                    2, 4'd4, 32'h11, 4'd5, 32'h22, 4'd0, 32'd0};
        vecs[3] = '{"empty_list", mk(0,1,1,0,4'd1,16'h0000), 32'h1000, 0, 1, 2, 0,
                    32'd0, 32'd0, 32'd0, 32'd0,
                    0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0};
        vecs[4] = '{"stmda_wrap", mk(0,0,0,0,4'd7,16'h0003), 32'h4, 0, 0, 4, 2,
                    32'h0, 32'hA000_0000, 32'h4, 32'hA000_0001,
                    0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0};
        vecs[5] = '{"stmib_wait3", mk(1,1,1,0,4'd0,16'h0001), 32'h0, 3, 0, 7, 1,
                    32'h4, 32'hA000_0000, 32'd0, 32'd0,
                    1, 4'd0, 32'h4, 4'd0, 32'd0, 4'd0, 32'd0};
        vecs[6] = '{"stmdb", mk(1,0,1,0,4'd13,16'h4002), 32'h100, 0, 0, 5, 2,
                    32'hF8, 32'hA000_0001, 32'hFC, 32'hA000_000E,
                    1, 4'd13, 32'hF8, 4'd0, 32'd0, 4'd0, 32'd0};
        vecs[7] = '{"ldmib_wb", mk(1,1,1,1,4'd8,16'h0200), 32'h10, 0, 0, 4, 1,
                    32'h14, 32'h55, 32'd0, 32'd0,
                    2, 4'd9, 32'h55, 4'd8, 32'h14, 4'd0, 32'd0};
        vecs[8] = '{"ldmda_wait1", mk(0,0,1,1,4'd3,16'h0006), 32'h4, 1, 0, 7, 2,
                    32'h0, 32'h77, 32'h4, 32'h88,
                    3, 4'd1, 32'h77, 4'd2, 32'h88, 4'd3, 32'hFFFF_FFFC};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.reg_wr_en,
             bus.reg_wr_addr, bus.reg_wr_data, bus.reg_rd_addr, bus.busy, bus.done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_after_reset", {bus.busy, bus.done, bus.mem_req}, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset during the second transfer of a 4-register store.
        @(negedge clk);
        bus.inst = mk(0, 1, 1, 0, 4'd0, 16'h000F); bus.rn_value = 32'h0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;                  // SETUP
        @(negedge clk); bus.mem_ready = 1'b1;              // first XFER
        @(negedge clk); bus.mem_ready = 1'b0;              // second XFER
        #1;
        chk("rst_pre_addr", {bus.mem_req, bus.mem_addr, bus.mem_wdata},
            {1'b1, 32'h4, 32'hA000_0001});
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.reg_wr_en,
             bus.reg_wr_addr, bus.reg_wr_data, bus.reg_rd_addr, bus.busy, bus.done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req || bus.reg_wr_en || bus.busy || bus.done) seen++;
        end
        bus.mem_ready = 1'b0;
        chk("rst_no_resume", seen, 0);

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_block_xfer_seq.md
# arm_block_xfer_seq

Multi-cycle sequencer for ARM block data transfers (LDM/STM). When the decoder presents a block-transfer instruction, this block walks the 16-bit register list and issues one word transfer per listed register over a request/ready memory handshake, reading or writing the register file port by port. It then optionally writes back the updated base register. It owns the register-file and memory ports for the whole instruction and holds `busy` to stall the rest of the core.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch a transfer. Sampled only in IDLE.
- `inst` in 32: block-transfer instruction. Fields used: P=inst[24], U=inst[23], W=inst[21], L=inst[20], Rn=inst[19:16], list=inst[15:0]. Captured on accepted `start`.
- `rn_value` in 32: value of Rn. Captured on accepted `start`.
- `reg_rd_addr` out 4: register-file read index (combinational read).
- `reg_rd_data` in 32: read data for `reg_rd_addr`, same cycle.
- `reg_wr_en` out 1: register-file write strobe.
- `reg_wr_addr` out 4: register-file write index.
- `reg_wr_data` out 32: register-file write data.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = store, 0 = load. Valid with `mem_req`.
- `mem_addr` out 32: word address. Valid with `mem_req`.
- `mem_wdata` out 32: store data. Valid with `mem_req` when `mem_we`.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_rdata` in 32: load data. Valid when `mem_ready`.
- `busy` out 1: sequencer is active (not IDLE).
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, XFER, WB, DONE.
- IDLE: `busy`=0.
  - On `start`=1, capture `inst` and `rn_value` and go to SETUP.
- SETUP (1 cycle):
  - Compute N = popcount(list).
  - Compute the start address, all arithmetic mod 2^32:
    - IA (P=0,U=1): Rn.
    - IB (P=1,U=1): Rn+4.
    - DA (P=0,U=0): Rn−4N+4.
    - DB (P=1,U=0): Rn−4N.
  - Compute the writeback value: U ? Rn+4N : Rn−4N.
  - Load the pending mask = list and set cur = lowest set bit.
  - If N=0, go to DONE: no transfers, no writeback. Otherwise go to XFER.
- XFER:
  - Drive `mem_req`=1, `mem_we`=!L, and `mem_addr` = current address.
  - For stores: `reg_rd_addr`=cur and `mem_wdata`=`reg_rd_data`.
  - Hold all request outputs stable until `mem_ready`.
  - On `mem_ready`:
    - For a load, assert `reg_wr_en` the same cycle with `reg_wr_addr`=cur and `reg_wr_data`=`mem_rdata`.
    - Clear cur from the mask and add 4 to the address.
    - If the mask becomes empty, go to WB if W=1, else go to DONE.
  - Registers transfer in ascending index order, lowest index at lowest address.
- WB (1 cycle):
  - `reg_wr_en`=1, `reg_wr_addr`=Rn, `reg_wr_data`=writeback value. Then go to DONE.
  - Exception: for a load with Rn in the list, suppress the WB write; the loaded value wins.
  - A store of Rn always stores the original `rn_value`, because writeback happens last.
- DONE (1 cycle): `done`=1, then IDLE.
- `start` asserted while `busy`=1 is ignored, not queued.
- R15 is treated as an ordinary index; PC side effects are the core's concern.

## Timing
- Reset values: all outputs 0; state IDLE; mask and address 0.
- Reset asserted mid-transfer: the transfer is abandoned immediately and no further request or write is issued after deassertion.
- `busy` rises the cycle after an accepted `start` and falls the cycle after DONE.
- Zero-wait memory (`mem_ready`=1 whenever `mem_req`=1): latency from `start` to `done` = 1 (SETUP) + N + W + 1 cycles.
- Each wait cycle with `mem_ready`=0 adds exactly one cycle. No output changes during a wait.
- `mem_ready` sampled while `mem_req`=0 is ignored.
- `reg_wr_en` is only ever high in the `mem_ready` cycle of a load, or in WB. It is never high for stores except in WB.
- `done` and `start` in the same cycle: `start` is ignored, because the block is not yet in IDLE.

## Test plan
- STMIA: Rn=r1=0x1000, list=0x000C (r2=0xAA, r3=0xBB), W=1, zero-wait.
  - Required: writes (0x1000,0xAA), (0x1004,0xBB); WB r1=0x1008.
  - `done` 5 cycles after `start`.
- LDMDB: Rn=0x2000, list=0x8001, W=0.
  - Required: reads from 0x1FF8→r0 and 0x1FFC→r15; no WB.
  - `done` 4 cycles after `start`.
- LDMIA with Rn=r4 in list=0x0030 and W=1, memory returns 0x11 then 0x22.
  - Required: r4=0x11, r5=0x22; no WB write to r4.
- Wait states: STMIB Rn=0x0, list=0x0001, with `mem_ready` low for 3 cycles.
  - Required: `mem_addr`=0x4 and `mem_wdata` held stable for 4 cycles; one transfer.
- Edge cases:
  - Empty list: `done` 2 cycles after `start`, with no `mem_req` and no `reg_wr_en`.
  - `start` pulsed while `busy`: ignored.
  - DA with Rn=0x4, list=0x0003: addresses wrap to 0x0 and 0x4, start = 0x4−8+4 = 0x0.
- Reset mid-operation: assert `rst_n`=0 during the second XFER of a 4-register STM.
  - Required: all outputs 0 asynchronously; IDLE after release.
  - No further `mem_req` until a new `start`.
